bus_arbiter_ctrl: RTL and testbench
===================================

Name: bus_arbiter_ctrl

Overview:
- Three-requester shared-bus arbiter that drives the accmodule, mstate and nb_interrupts signals checked by the team's arbiter property set.
- M1 is high priority: it holds the bus indefinitely, and may preempt M2/M3 for a bounded slice.
- M2/M3 are low priority, time-sliced and rotated.
- Sits between the M1-M3 request/done pulses and the bus mux select.

Parameters:
- LP_SLICE, 2, max consecutive grant cycles for M2 or M3 (range 1-15).
- INTR_SLICE, 2, max grant cycles for M1 when it preempts M2/M3 (range 1-15).
- CNT_W, 16, width of nb_interrupts; the counter saturates at all-ones.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req  in  3  one-cycle request pulses; bit0=M1, bit1=M2, bit2=M3
- done  in  3  one-cycle release pulses, same bit order; never coincident with req of the same bit
- accmodule  out  2  registered grant: 00 none, 01 M1, 10 M2, 11 M3
- mstate  out  5  one-hot state: bit0 IDLE, bit1 M1_OWN, bit2 M2_OWN, bit3 M3_OWN, bit4 M1_INTR
- nb_interrupts  out  CNT_W  count of M1 preemptions since reset

Behaviour:
- Reset (reset==0 at posedge):
  - accmodule=00, mstate=00001, nb_interrupts=0.
  - Pending bits, slice counter, saved owner and RR pointer are cleared.
  - Applies mid-grant; an in-flight owner is dropped with no resume.
- Pending requests:
  - Because req is a pulse, pend[i] is set on req[i] and cleared in the cycle module i is granted.
  - req for the current owner is ignored.
- All transitions are registered: a decision made in cycle N is visible on accmodule/mstate in cycle N+1. There is no same-cycle grant.
- Selection (used on any release):
  - M1 pending or req[0] wins.
  - Otherwise M2 vs M3 is chosen by the selection rule in Optional Feature.
  - Otherwise IDLE.
  - Effective request = pend | req.
- IDLE: on any effective request, go to the selected owner's state and load slice=1.
- M1_OWN:
  - Holds until done[0], with no time limit.
  - On done[0], select the next owner in the same edge. A smooth handover has no idle gap (e.g. done[0]&req[1] -> accmodule=10 next cycle).
- M2_OWN / M3_OWN:
  - Slice increments each cycle.
  - Release on done of the owner, or when slice==LP_SLICE, then select the next owner. The expired owner is not re-granted unless it has a fresh pending request.
  - If req[0] or pend[0] arrives while the owner has not asserted done:
    - go to M1_INTR;
    - save the owner;
    - set that owner's pend bit so it resumes later;
    - increment nb_interrupts (saturating).
  - If done[owner] and req[0] arrive in the same cycle, it is a normal handover to M1_OWN: no interrupt and no count.
- M1_INTR:
  - accmodule=01. Release on done[0] or after INTR_SLICE cycles.
  - Then select the next owner; the resumed M2/M3 starts a fresh slice=1.
  - A new req[0] during M1_INTR is ignored.
- done for a non-owner is ignored; it never changes state.
- mstate is always exactly one-hot and consistent with accmodule: IDLE<->00, M1_OWN/M1_INTR<->01, M2_OWN<->10, M3_OWN<->11.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: M2/M3 are chosen round-robin. A 1-bit pointer toggles on each M2/M3 grant, and when both are pending the one not most recently granted wins.
- Undefined: fixed priority, M2 over M3. The pointer logic is not compiled.

Test Plan:
- Idle, req=001 one cycle -> accmodule=01 next cycle; held 20 cycles with no done; done=001 -> accmodule=00 next cycle.
- Idle, req=010, no done, no other req -> accmodule=10 for exactly 2 cycles, then 00; mstate 00100 -> 00001.
- M3 owns cycle 1, req=001 -> accmodule=01 for 2 cycles (mstate=10000), nb_interrupts 0->1, then accmodule=11 for 2 cycles, then 00.
- M1 owns, done=001 with req=100 same cycle -> next cycle accmodule=11, no 00 gap.
- ARB_RR_EN on: req=110 together from idle -> grants M2, M3, M2, ... across repeated pairs; off -> always M2 first.
- Reset asserted (0) during M1_INTR with pending M2 -> next cycle accmodule=00, mstate=00001, nb_interrupts=0; M2 not granted afterward.

Source files
------------

// File: rtl/bus_arbiter_ctrl.sv
// bus_arbiter_ctrl: three-requester bus arbiter; M1 high priority with bounded preemption of time-sliced M2/M3.
// Latency: one cycle; a decision taken at clock edge N is visible on accmodule/mstate right after edge N.
// Backpressure: none; req/done are pulses, and requests not yet served are held in pend until granted.
// Build option: define ARB_RR_EN for round-robin M2/M3 selection (default build: fixed M2 over M3).
module bus_arbiter_ctrl #(
  parameter int LP_SLICE   = 2,
  parameter int INTR_SLICE = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       done,
  output logic [1:0]       accmodule,
  output logic [4:0]       mstate,
  output logic [CNT_W-1:0] nb_interrupts
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_M1_OWN  = 3'd1,
    S_M2_OWN  = 3'd2,
    S_M3_OWN  = 3'd3,
    S_M1_INTR = 3'd4
  } state_t;

  localparam logic [3:0] LP_LIM   = 4'(LP_SLICE);
  localparam logic [3:0] INTR_LIM = 4'(INTR_SLICE);

  state_t     state;
  logic [2:0] pend;       // requests seen but not yet granted; also marks a preempted M2/M3 for resume
  logic [3:0] slice;      // cycles spent by the current owner (M2/M3 slice or M1 preemption slice)
`ifdef ARB_RR_EN
  logic       rr_m3_next; // 1: on an M2/M3 tie, M3 wins (M2 was granted most recently)
`endif

  logic [2:0] own_mask;
  logic [2:0] eff;
  logic [1:0] pick;
  logic       release_now;
  logic       preempt;

  // Effective requests: pending plus fresh pulses, dropping a req from the current owner
  // (and any new M1 req while M1 is already on the bus).
  always_comb begin
    own_mask = 3'b000;
    case (state)
      S_M1_OWN, S_M1_INTR: own_mask = 3'b001;
      S_M2_OWN:            own_mask = 3'b010;
      S_M3_OWN:            own_mask = 3'b100;
      default:             own_mask = 3'b000;
    endcase
    eff = pend | (req & ~own_mask);
  end

  // Next-owner selection: M1 first, then M2/M3 by fixed priority or round-robin, else none.
  always_comb begin
    pick = 2'b00;
    if (eff[0]) begin
      pick = 2'b01;
    end else if (eff[1] && eff[2]) begin
`ifdef ARB_RR_EN
      pick = rr_m3_next ? 2'b11 : 2'b10;
`else
      pick = 2'b10;
`endif
    end else if (eff[1]) begin
      pick = 2'b10;
    end else if (eff[2]) begin
      pick = 2'b11;
    end
  end

  // Release / preemption decision for the current state. A done from the owner in the same
  // cycle as an M1 request is an ordinary handover, so preemption requires no release.
  always_comb begin
    release_now = 1'b0;
    preempt     = 1'b0;
    case (state)
      S_IDLE:    release_now = 1'b1;
      S_M1_OWN:  release_now = done[0];
      S_M2_OWN: begin
        release_now = done[1] || (slice == LP_LIM);
        preempt     = !release_now && eff[0];
      end
      S_M3_OWN: begin
        release_now = done[2] || (slice == LP_LIM);
        preempt     = !release_now && eff[0];
      end
      S_M1_INTR: release_now = done[0] || (slice == INTR_LIM);
      default:   release_now = 1'b1;
    endcase
  end

  // Arbiter FSM with registered grant, one-hot state and preemption counter.
  // The preempted owner is remembered through its pend bit and comes back via normal selection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      accmodule     <= 2'b00;
      mstate        <= 5'b00001;
      nb_interrupts <= '0;
      pend          <= 3'b000;
      slice         <= 4'd0;
`ifdef ARB_RR_EN
      rr_m3_next    <= 1'b0;
`endif
    end else if (preempt) begin
      state     <= S_M1_INTR;
      accmodule <= 2'b01;
      mstate    <= 5'b10000;
      slice     <= 4'd1;
      pend      <= (eff & 3'b110) | own_mask;
      if (nb_interrupts != '1) begin
        nb_interrupts <= nb_interrupts + CNT_W'(1);
      end
    end else if (release_now) begin
      slice <= 4'd1;
      case (pick)
        2'b01: begin
          state     <= S_M1_OWN;
          accmodule <= 2'b01;
          mstate    <= 5'b00010;
          pend      <= eff & 3'b110;
        end
        2'b10: begin
          state     <= S_M2_OWN;
          accmodule <= 2'b10;
          mstate    <= 5'b00100;
          pend      <= eff & 3'b101;
`ifdef ARB_RR_EN
          rr_m3_next <= 1'b1;
`endif
        end
        2'b11: begin
          state     <= S_M3_OWN;
          accmodule <= 2'b11;
          mstate    <= 5'b01000;
          pend      <= eff & 3'b011;
`ifdef ARB_RR_EN
          rr_m3_next <= 1'b0;
`endif
        end
        default: begin
          state     <= S_IDLE;
          accmodule <= 2'b00;
          mstate    <= 5'b00001;
          pend      <= eff;
        end
      endcase
    end else begin
      pend <= eff;
      if (state != S_M1_OWN) begin
        slice <= slice + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Directed bench for bus_arbiter_ctrl: fixed cycle sequences with hand-computed grants.
// The counter is narrowed to 3 bits so saturation is reachable in a few cycles.
module tb_bus_arbiter_ctrl;

  localparam int CW = 3;

`ifdef ARB_RR_EN
  // The last grant before the pair test goes to M2, so round-robin favours M3 on the tie.
  localparam logic [1:0] FIRST_ACC  = 2'b11;
  localparam logic [4:0] FIRST_MS   = 5'b01000;
  localparam logic [1:0] SECOND_ACC = 2'b10;
  localparam logic [4:0] SECOND_MS  = 5'b00100;
`else
  localparam logic [1:0] FIRST_ACC  = 2'b10;
  localparam logic [4:0] FIRST_MS   = 5'b00100;
  localparam logic [1:0] SECOND_ACC = 2'b11;
  localparam logic [4:0] SECOND_MS  = 5'b01000;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req;
  logic [2:0]    done;
  logic [1:0]    accmodule;
  logic [4:0]    mstate;
  logic [CW-1:0] nb_interrupts;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter_ctrl #(
    .LP_SLICE   (2),
    .INTR_SLICE (2),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .done          (done),
    .accmodule     (accmodule),
    .mstate        (mstate),
    .nb_interrupts (nb_interrupts)
  );

  // Present req/done for one clock edge, then return to idle inputs 1 time unit after it.
  task automatic cyc(input logic [2:0] r, input logic [2:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
    req  = 3'b000;
    done = 3'b000;
  endtask

  task automatic check(input string tag, input logic [1:0] ea, input logic [4:0] em, input int en);
    logic [CW-1:0] enb;
    enb = CW'(en);
    n_assert++;
    assert ({accmodule, mstate, nb_interrupts} === {ea, em, enb}) else begin
      n_fail++;
      $error("FAIL %s: acc=%b mstate=%b nb=%0d, expected acc=%b mstate=%b nb=%0d",
             tag, accmodule, mstate, nb_interrupts, ea, em, enb);
    end
  endtask

  initial begin
    reset = 1'b0;
    req   = 3'b000;
    done  = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 2'b00, 5'b00001, 0);
    reset = 1'b1;
    cyc(3'b000, 3'b000);
    check("idle_after_reset", 2'b00, 5'b00001, 0);

    // M1 grant, unlimited hold, release on done
    cyc(3'b001, 3'b000);
    check("m1_grant", 2'b01, 5'b00010, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(3'b000, 3'b000);
      check("m1_hold", 2'b01, 5'b00010, 0);
    end
    cyc(3'b000, 3'b001);
    check("m1_release", 2'b00, 5'b00001, 0);

    // M2 slice expiry after exactly 2 cycles, no re-grant
    cyc(3'b010, 3'b000);
    check("m2_slice_c1", 2'b10, 5'b00100, 0);
    cyc(3'b000, 3'b000);
    check("m2_slice_c2", 2'b10, 5'b00100, 0);
    cyc(3'b000, 3'b000);
    check("m2_expired", 2'b00, 5'b00001, 0);

    // M3 preempted on its first cycle; a second M1 req during M1_INTR is ignored
    cyc(3'b100, 3'b000);
    check("m3_grant", 2'b11, 5'b01000, 0);
    cyc(3'b001, 3'b000);
    check("intr_c1", 2'b01, 5'b10000, 1);
    cyc(3'b001, 3'b000);
    check("intr_c2", 2'b01, 5'b10000, 1);
    cyc(3'b000, 3'b000);
    check("m3_resume_c1", 2'b11, 5'b01000, 1);
    cyc(3'b000, 3'b000);
    check("m3_resume_c2", 2'b11, 5'b01000, 1);
    cyc(3'b000, 3'b000);
    check("after_resume", 2'b00, 5'b00001, 1);

    // Smooth handover M1 -> M3 with no idle gap
    cyc(3'b001, 3'b000);
    check("m1_grant2", 2'b01, 5'b00010, 1);
    cyc(3'b100, 3'b001);
    check("handover_m3", 2'b11, 5'b01000, 1);
    cyc(3'b000, 3'b000);
    check("handover_m3_c2", 2'b11, 5'b01000, 1);
    cyc(3'b000, 3'b000);
    check("handover_end", 2'b00, 5'b00001, 1);

    // done from M2 together with req from M1: plain handover, no count
    cyc(3'b010, 3'b000);
    check("m2_grant2", 2'b10, 5'b00100, 1);
    cyc(3'b001, 3'b010);
    check("m2_to_m1_no_intr", 2'b01, 5'b00010, 1);
    cyc(3'b000, 3'b001);
    check("m1_release2", 2'b00, 5'b00001, 1);

    // done from non-owners is ignored
    cyc(3'b010, 3'b000);
    check("m2_grant3", 2'b10, 5'b00100, 1);
    cyc(3'b000, 3'b101);
    check("nonowner_done", 2'b10, 5'b00100, 1);
    cyc(3'b000, 3'b000);
    check("nonowner_expire", 2'b00, 5'b00001, 1);

    // Simultaneous M2+M3 requests, two rounds
    for (int p = 0; p < 2; p++) begin
      cyc(3'b110, 3'b000);
      check("pair_first_c1", FIRST_ACC, FIRST_MS, 1);
      cyc(3'b000, 3'b000);
      check("pair_first_c2", FIRST_ACC, FIRST_MS, 1);
      cyc(3'b000, 3'b000);
      check("pair_second_c1", SECOND_ACC, SECOND_MS, 1);
      cyc(3'b000, 3'b000);
      check("pair_second_c2", SECOND_ACC, SECOND_MS, 1);
      cyc(3'b000, 3'b000);
      check("pair_idle", 2'b00, 5'b00001, 1);
    end

    // Reset during M1_INTR with M2 pending: everything dropped
    cyc(3'b010, 3'b000);
    check("m2_grant4", 2'b10, 5'b00100, 1);
    cyc(3'b001, 3'b000);
    check("intr_before_reset", 2'b01, 5'b10000, 2);
    reset = 1'b0;
    cyc(3'b000, 3'b000);
    check("reset_mid_intr", 2'b00, 5'b00001, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(3'b000, 3'b000);
      check("no_resume_after_reset", 2'b00, 5'b00001, 0);
    end

    // Counter saturation at all-ones, also exercising early done[0] from M1_INTR
    cyc(3'b010, 3'b000);
    check("sat_m2_grant", 2'b10, 5'b00100, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc(3'b001, 3'b000);
      check("sat_intr", 2'b01, 5'b10000, (k > 7) ? 7 : k);
      cyc(3'b000, 3'b001);
      check("sat_resume", 2'b10, 5'b00100, (k > 7) ? 7 : k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
